// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read-side and serial-line signal bundle for uart_tx_fifo_drain.
// slave = transmitter side, master = FIFO/config/line-observer side.
interface uart_tx_fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  FIFO_EMPTY;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  RD_INC;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;

  modport master (
    output FIFO_EMPTY, RD_DATA, PAR_EN, PAR_TYP,
    input  RD_INC, TX_OUT, BUSY
  );

  modport slave (
    input  FIFO_EMPTY, RD_DATA, PAR_EN, PAR_TYP,
    output RD_INC, TX_OUT, BUSY
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a show-ahead FIFO: start, data LSB first, optional parity, stop.
// Define UART_TX_STOP2_EN to append a second stop bit (STOP2 state).
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_tx_fifo_drain_if.slave   bus
);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
`ifdef UART_TX_STOP2_EN
    ST_STOP,
    ST_STOP2
`else
    ST_STOP
`endif
  } state_t;

  // The state at whose end the next byte may be fetched without an idle gap.
`ifdef UART_TX_STOP2_EN
  localparam state_t ST_LAST_STOP = ST_STOP2;
`else
  localparam state_t ST_LAST_STOP = ST_STOP;
`endif

  state_t                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic                  par_en_q,  par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_out_q,  tx_out_d;
  logic                  busy_q,    busy_d;
  logic                  rd_inc_q,  rd_inc_d;
  logic                  fetch;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
      rd_inc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      rd_inc_q  <= rd_inc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_out_d  = tx_out_q;
    busy_d    = busy_q;
    rd_inc_d  = 1'b0;
    fetch     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
      end
      ST_START: begin
        tx_out_d = shift_q[0];
        shift_d  = shift_q >> 1;
        cnt_d    = '0;
        state_d  = ST_DATA;
      end
      ST_DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          if (par_en_q) begin
            tx_out_d = par_bit_q;
            state_d  = ST_PARITY;
          end else begin
            tx_out_d = 1'b1;
            state_d  = ST_STOP;
          end
        end else begin
          tx_out_d = shift_q[0];
          shift_d  = shift_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        tx_out_d = 1'b1;
        state_d  = ST_STOP;
      end
`ifdef UART_TX_STOP2_EN
      ST_STOP: begin
        tx_out_d = 1'b1;
        state_d  = ST_STOP2;
      end
      ST_STOP2: begin
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
`else
      ST_STOP: begin
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
`endif
      default: begin
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // Fetch overrides the idle/stop defaults so back-to-back frames have no gap.
    if ((state_q == ST_IDLE || state_q == ST_LAST_STOP) && !bus.FIFO_EMPTY) begin
      fetch     = 1'b1;
      shift_d   = bus.RD_DATA;
      rd_inc_d  = 1'b1;
      par_en_d  = bus.PAR_EN;
      par_bit_d = (^bus.RD_DATA) ^ bus.PAR_TYP;
      tx_out_d  = 1'b0;
      busy_d    = 1'b1;
      cnt_d     = '0;
      state_d   = ST_START;
    end
  end

  assign bus.TX_OUT = tx_out_q;
  assign bus.BUSY   = busy_q;
  assign bus.RD_INC = rd_inc_q;
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench for uart_tx_fifo_drain: a FIFO model feeds bytes, a line monitor
// decodes frames and compares them against frames predicted from the bytes pushed.
module tb_uart_tx_fifo_drain;
  localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  localparam int LEN_NOPAR = 1 + DW + STOP_BITS;

  logic clk;
  logic rst;

  uart_tx_fifo_drain_if #(.DATA_WIDTH(DW)) bus();

  uart_tx_fifo_drain #(.DATA_WIDTH(DW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: main process writes, pop process reads.
  logic [7:0] fifo_mem [0:1023];
  logic [9:0] wr_ptr = '0;
  logic [9:0] rd_ptr = '0;
  assign bus.FIFO_EMPTY = (wr_ptr == rd_ptr);
  assign bus.RD_DATA    = fifo_mem[rd_ptr];

  // Expected frames: pushed with the byte, popped by the monitor at each start bit.
  logic [7:0] exp_d  [0:1023];
  logic       exp_pe [0:1023];
  logic       exp_pt [0:1023];
  int exp_wr = 0;
  int exp_rd = 0;

  // Monitor statistics.
  int cyc        = 0;
  int busy_cnt   = 0;
  int nframes    = 0;
  int last_start = 0;
  int prev_start = 0;

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr           = wr_ptr + 10'd1;
    exp_d[exp_wr]    = d;
    exp_pe[exp_wr]   = bus.PAR_EN;
    exp_pt[exp_wr]   = bus.PAR_TYP;
    exp_wr++;
    $display("push 0x%02h par_en=%0d par_typ=%0d", d, bus.PAR_EN, bus.PAR_TYP);
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (wr_ptr == rd_ptr && !bus.BUSY && exp_rd == exp_wr) begin
        done = 1'b1;
        break;
      end
    end
    check_bit("drain_within_budget", done, 1'b1);
  endtask

  // FIFO pop: RD_INC is high for the cycle after the fetch edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.RD_INC === 1'b1) begin
        check_bit("pop_nonempty", (wr_ptr != rd_ptr), 1'b1);
        rd_ptr = rd_ptr + 10'd1;
      end
    end
  end

  // Line monitor: acts as a receiver, one sample per bit cycle.
  initial begin
    logic        in_frame;
    logic [15:0] bits;
    int          flen;
    int          idx;
    logic [7:0]  d;
    logic        par;
    in_frame = 1'b0;
    flen     = 0;
    idx      = 0;
    bits     = '1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_frame = 1'b0;
      end else begin
        if (bus.BUSY === 1'b1) busy_cnt++;
        if (!in_frame) begin
          if (bus.TX_OUT === 1'b0) begin
            n_checks++;
            if (exp_rd == exp_wr) begin
              n_fail++;
              $display("FAIL unexpected_frame: start bit at cycle %0d, required idle line", cyc);
            end else begin
              d    = exp_d[exp_rd];
              bits = '1;
              bits[0] = 1'b0;
              for (int i = 0; i < DW; i++) bits[1+i] = d[i];
              flen = 1 + DW;
              if (exp_pe[exp_rd]) begin
                par        = (($countones(d) % 2) == 1);
                bits[flen] = par ^ exp_pt[exp_rd];
                flen++;
              end
              flen += STOP_BITS;
              $display("frame %0d: data 0x%02h par_en=%0d len=%0d start cycle %0d",
                       nframes, d, exp_pe[exp_rd], flen, cyc);
              exp_rd++;
              in_frame   = 1'b1;
              idx        = 0;
              prev_start = last_start;
              last_start = cyc;
              nframes++;
            end
          end else begin
            check_bit("idle_busy", bus.BUSY, 1'b0);
            check_bit("idle_rd_inc", bus.RD_INC, 1'b0);
          end
        end
        if (in_frame) begin
          check_bit($sformatf("tx_bit[%0d]", idx), bus.TX_OUT, bits[idx]);
          check_bit("frame_busy", bus.BUSY, 1'b1);
          check_bit("frame_rd_inc", bus.RD_INC, (idx == 0));
          idx++;
          if (idx == flen) in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    int f0;
    rst         = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("reset_tx_out", bus.TX_OUT, 1'b1);
    check_bit("reset_busy", bus.BUSY, 1'b0);
    check_bit("reset_rd_inc", bus.RD_INC, 1'b0);
    rst = 1'b0;

    // Empty FIFO for 50 cycles: monitor checks idle every cycle.
    repeat (50) @(negedge clk);
    check_int("empty_no_frames", nframes, 0);
    check_bit("empty_tx_out", bus.TX_OUT, 1'b1);

    // Single 0xA5 without parity, start bit right after the sampling edge.
    b0 = busy_cnt;
    push(8'hA5);
    @(posedge clk);
    #1;
    check_bit("latency_start_bit", bus.TX_OUT, 1'b0);
    check_bit("latency_rd_inc", bus.RD_INC, 1'b1);
    check_bit("latency_busy", bus.BUSY, 1'b1);
    wait_idle(100);
    check_int("single_busy_cycles", busy_cnt - b0, LEN_NOPAR);

    // Parity frames.
    @(negedge clk);
    bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
    b0 = busy_cnt;
    push(8'hA5);
    wait_idle(100);
    check_int("parity_busy_cycles", busy_cnt - b0, LEN_NOPAR + 1);
    @(negedge clk);
    bus.PAR_TYP = 1'b1;
    push(8'hA5);
    wait_idle(100);
    @(negedge clk);
    bus.PAR_TYP = 1'b0;
    push(8'h07);
    wait_idle(100);

    // Back-to-back 0x01, 0x80 with no idle gap.
    @(negedge clk);
    bus.PAR_EN = 1'b0;
    b0 = busy_cnt;
    push(8'h01);
    push(8'h80);
    wait_idle(100);
    check_int("b2b_start_spacing", last_start - prev_start, LEN_NOPAR);
    check_int("b2b_busy_cycles", busy_cnt - b0, 2 * LEN_NOPAR);

    // Reset during data bit 3 of 0xFF.
    @(negedge clk);
    f0 = nframes;
    push(8'hFF);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_bit("async_rst_tx_out", bus.TX_OUT, 1'b1);
    check_bit("async_rst_busy", bus.BUSY, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_int("rst_no_refetch_frames", nframes - f0, 1);
    check_bit("rst_line_idle", bus.TX_OUT, 1'b1);
    check_bit("rst_fifo_empty", bus.FIFO_EMPTY, 1'b1);

    // Config change mid-frame: applies to the next fetch only.
    @(negedge clk);
    bus.PAR_EN = 1'b0;
    b0 = busy_cnt;
    push(8'h3C);
    repeat (4) @(negedge clk);
    bus.PAR_EN = 1'b1;
    push(8'h3C);
    wait_idle(100);
    check_int("cfg_first_frame_len", last_start - prev_start, LEN_NOPAR);
    check_int("cfg_busy_cycles", busy_cnt - b0, 2 * LEN_NOPAR + 1);

    // Randomised rounds: config fixed per round, bytes pushed with random gaps.
    for (int r = 0; r < 30; r++) begin
      int nb;
      @(negedge clk);
      bus.PAR_EN  = 1'($urandom_range(0, 1));
      bus.PAR_TYP = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        repeat ($urandom_range(0, 12)) @(negedge clk);
        push(8'($urandom_range(0, 255)));
      end
      wait_idle(300);
    end

    check_int("scoreboard_drained", exp_wr - exp_rd, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
